// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic feeder and PE array: FSM encoding, run length
// and MSB-first lane slicing so both sides agree on element ordering.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Cycles needed for skew fill, K operands, propagation to the far corner PE and its MAC register.
  function automatic int t_run(input int k_depth, input int x_row, input int y_col);
    return k_depth + x_row + y_col - 1;
  endfunction

  // MSB bit position of element idx in a packed vector of n elements, element 0 at the top.
  function automatic int slice_msb(input int idx, input int n, input int width);
    return n * width - 1 - idx * width;
  endfunction

endpackage

// File: rtl/skew_lane_select.sv
// Picks the operand a skewed lane presents at step t: element t-LANE of its vector,
// or zero while the lane is still filling or already drained.
module skew_lane_select
  import systolic_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int K_DEPTH  = 3,
  parameter int LANE     = 0,
  parameter int CNT_W    = 4
) (
  input  logic [CNT_W-1:0]            t,
  input  logic [K_DEPTH*BITWIDTH-1:0] vec,
  output logic [BITWIDTH-1:0]         operand
);

  // NOTE: operand gets its zero default before the loop, so no path leaves it unassigned (no latch).
  always_comb begin
    operand = '0;
    for (int k = 0; k < K_DEPTH; k++) begin
      if (int'(t) == LANE + k) begin
        operand = vec[slice_msb(k, K_DEPTH, BITWIDTH) -: BITWIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Captures X and Y, then streams them diagonally skewed into the systolic PE array
// together with the PE enable, accumulator clear, busy and done controls.
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int X_ROW    = 3,
  parameter int Y_COL    = 3,
  parameter int K_DEPTH  = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                hold,
  input  logic [X_ROW*K_DEPTH*BITWIDTH-1:0]   mat_x,
  input  logic [K_DEPTH*Y_COL*BITWIDTH-1:0]   mat_y,
  output logic [X_ROW*BITWIDTH-1:0]           out_row,
  output logic [Y_COL*BITWIDTH-1:0]           out_col,
  output logic                                pe_en,
  output logic                                acc_clr,
  output logic                                busy,
  output logic                                done
);

  localparam int T_RUN = t_run(K_DEPTH, X_ROW, Y_COL);
  localparam int CNT_W = $clog2(T_RUN + 1);
  localparam int VEC_W = K_DEPTH * BITWIDTH;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T_RUN - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]                    t_q, t_d, t_sel;
  logic [X_ROW*K_DEPTH*BITWIDTH-1:0]   x_q;
  logic [K_DEPTH*Y_COL*BITWIDTH-1:0]   y_q;
  logic [X_ROW*BITWIDTH-1:0]           row_sel, row_d;
  logic [Y_COL*BITWIDTH-1:0]           col_sel, col_d;
  logic                                pe_en_d;
  logic                                capture;

  assign capture = (state_q == IDLE) && start;

  // NOTE: operand snapshots carry no reset; they are only read after a capture has filled them.
  always_ff @(posedge clk) begin
    if (capture) begin
      x_q <= mat_x;
      y_q <= mat_y;
    end
  end

  // A row of X is contiguous in the packed matrix, so each row lane takes its slice directly.
  for (genvar i = 0; i < X_ROW; i++) begin : g_row
    skew_lane_select #(
      .BITWIDTH (BITWIDTH),
      .K_DEPTH  (K_DEPTH),
      .LANE     (i),
      .CNT_W    (CNT_W)
    ) u_sel (
      .t       (t_sel),
      .vec     (x_q[slice_msb(i, X_ROW, VEC_W) -: VEC_W]),
      .operand (row_sel[slice_msb(i, X_ROW, BITWIDTH) -: BITWIDTH])
    );
  end

  // A column of Y is strided, so gather it into a K_DEPTH-element vector first.
  for (genvar j = 0; j < Y_COL; j++) begin : g_col
    logic [VEC_W-1:0] col_vec;

    for (genvar k = 0; k < K_DEPTH; k++) begin : g_gather
      assign col_vec[slice_msb(k, K_DEPTH, BITWIDTH) -: BITWIDTH] =
        y_q[slice_msb(k * Y_COL + j, K_DEPTH * Y_COL, BITWIDTH) -: BITWIDTH];
    end

    skew_lane_select #(
      .BITWIDTH (BITWIDTH),
      .K_DEPTH  (K_DEPTH),
      .LANE     (j),
      .CNT_W    (CNT_W)
    ) u_sel (
      .t       (t_sel),
      .vec     (col_vec),
      .operand (col_sel[slice_msb(j, Y_COL, BITWIDTH) -: BITWIDTH])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // t_sel is the step about to be presented; streams and pe_en are registered from it.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    t_sel   = '0;
    row_d   = out_row;
    col_d   = out_col;
    pe_en_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
        t_d     = '0;
        row_d   = row_sel;
        col_d   = col_sel;
        pe_en_d = 1'b1;
      end
      RUN: begin
        if (!hold) begin
          if (t_q == T_LAST) begin
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
          end else begin
            t_d     = t_q + 1'b1;
            t_sel   = t_q + 1'b1;
            row_d   = row_sel;
            col_d   = col_sel;
            pe_en_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q     <= '0;
      out_row <= '0;
      out_col <= '0;
      pe_en   <= 1'b0;
      acc_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      t_q     <= t_d;
      out_row <= row_d;
      out_col <= col_d;
      pe_en   <= pe_en_d;
      acc_clr <= (state_d == LOAD);
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder with a small behavioural PE array
// attached to the skewed streams so end-of-run products can be checked.
module tb_systolic_operand_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hold;
  logic [71:0] mat_x;
  logic [71:0] mat_y;
  logic [23:0] out_row;
  logic [23:0] out_col;
  logic        pe_en;
  logic        acc_clr;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  localparam logic [71:0] X_TEST = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [71:0] Y_ID   = 72'h01_00_00_00_01_00_00_00_01;
  localparam logic [23:0] EXP_ROW [0:7] = '{24'h010000, 24'h020400, 24'h030507, 24'h000608,
                                             24'h000009, 24'h000000, 24'h000000, 24'h000000};
  localparam logic [23:0] EXP_COL [0:7] = '{24'h010000, 24'h000000, 24'h000100, 24'h000000,
                                             24'h000001, 24'h000000, 24'h000000, 24'h000000};
  localparam int EXP_X [0:2][0:2] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};

  always #5 clk = ~clk;

  systolic_operand_feeder #(
    .BITWIDTH (8),
    .X_ROW    (3),
    .Y_COL    (3),
    .K_DEPTH  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hold    (hold),
    .mat_x   (mat_x),
    .mat_y   (mat_y),
    .out_row (out_row),
    .out_col (out_col),
    .pe_en   (pe_en),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done)
  );

  // Behavioural output-stationary PE array: a flows right, b flows down, acc += a*b when enabled.
  int                 acc   [0:2][0:2];
  logic signed [7:0]  a_reg [0:2][0:2];
  logic signed [7:0]  b_reg [0:2][0:2];
  logic signed [7:0]  ai, bi;

  always @(posedge clk or posedge rst) begin
    if (rst || acc_clr) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          acc[i][j]   <= 0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
      end
    end else if (pe_en) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          ai = (j == 0) ? out_row[23-8*i -: 8] : a_reg[i][j-1];
          bi = (i == 0) ? out_col[23-8*j -: 8] : b_reg[i-1][j];
          acc[i][j]   <= acc[i][j] + int'(ai) * int'(bi);
          a_reg[i][j] <= ai;
          b_reg[i][j] <= bi;
        end
      end
    end
  end

  logic [23:0] obs_row  [0:19];
  logic [23:0] obs_col  [0:19];
  logic        obs_pe   [0:19];
  logic        obs_clr  [0:19];
  logic        obs_done [0:19];
  logic        obs_busy [0:19];

  // Pulses start in cycle 0 and records cycles 1..n; hold, extra starts and an X change are driven per cycle.
  task automatic record(input int n, input int hold_from, input int hold_len,
                        input logic [31:0] start_mask, input int x_cycle, input logic [71:0] x_new);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs_row[c]  = out_row;
      obs_col[c]  = out_col;
      obs_pe[c]   = pe_en;
      obs_clr[c]  = acc_clr;
      obs_done[c] = done;
      obs_busy[c] = busy;
      start = start_mask[c];
      hold  = (c >= hold_from) && (c < hold_from + hold_len);
      if (c == x_cycle) mat_x = x_new;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      mat_x = 72'({$urandom, $urandom, $urandom});
      mat_y = 72'({$urandom, $urandom, $urandom});
      start = 1'($urandom_range(0, 1));
      hold  = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if ({out_row, out_col, pe_en, acc_clr, busy, done} !== 52'd0) begin
        bad++;
        $display("FAIL reset_outputs n=%0d got row=%h col=%h pe=%b clr=%b busy=%b done=%b want all 0",
                 n, out_row, out_col, pe_en, acc_clr, busy, done);
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    rst   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || pe_en !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset c=%0d got busy=%b pe_en=%b want 0 0", c, busy, pe_en);
      end
    end
  endtask

  task automatic test_skew();
    logic [23:0] er, ec;
    mat_x = X_TEST;
    mat_y = Y_ID;
    record(12, 0, 0, 32'd0, 0, 72'd0);
    for (int c = 1; c <= 12; c++) begin
      er = (c >= 2 && c <= 9) ? EXP_ROW[c-2] : 24'd0;
      ec = (c >= 2 && c <= 9) ? EXP_COL[c-2] : 24'd0;
      total++;
      if (obs_row[c] !== er) begin
        bad++;
        $display("FAIL skew_row c=%0d got=%h want=%h", c, obs_row[c], er);
      end
      total++;
      if (obs_col[c] !== ec) begin
        bad++;
        $display("FAIL skew_col c=%0d got=%h want=%h", c, obs_col[c], ec);
      end
      total++;
      if (obs_pe[c] !== (c >= 2 && c <= 9)) begin
        bad++;
        $display("FAIL skew_pe_en c=%0d got=%b want=%b", c, obs_pe[c], (c >= 2 && c <= 9));
      end
      total++;
      if (obs_clr[c] !== (c == 1)) begin
        bad++;
        $display("FAIL skew_acc_clr c=%0d got=%b want=%b", c, obs_clr[c], (c == 1));
      end
      total++;
      if (obs_done[c] !== (c == 10)) begin
        bad++;
        $display("FAIL skew_done c=%0d got=%b want=%b", c, obs_done[c], (c == 10));
      end
      total++;
      if (obs_busy[c] !== (c <= 10)) begin
        bad++;
        $display("FAIL skew_busy c=%0d got=%b want=%b", c, obs_busy[c], (c <= 10));
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (acc[i][j] !== EXP_X[i][j]) begin
          bad++;
          $display("FAIL skew_array pe(%0d,%0d) got=%0d want=%0d", i, j, acc[i][j], EXP_X[i][j]);
        end
      end
    end
  endtask

  task automatic test_hold();
    int          t;
    logic [23:0] er, ec;
    logic        ep;
    mat_x = X_TEST;
    mat_y = Y_ID;
    record(15, 4, 3, 32'd0, 0, 72'd0);
    for (int c = 1; c <= 15; c++) begin
      t  = (c < 2) ? -1 : (c <= 4) ? c - 2 : (c <= 7) ? 2 : (c <= 12) ? c - 5 : -1;
      ep = (c >= 2 && c <= 4) || (c >= 8 && c <= 12);
      er = (t >= 0) ? EXP_ROW[t] : 24'd0;
      ec = (t >= 0) ? EXP_COL[t] : 24'd0;
      total++;
      if (obs_row[c] !== er || obs_col[c] !== ec) begin
        bad++;
        $display("FAIL hold_streams c=%0d got row=%h col=%h want row=%h col=%h", c, obs_row[c], obs_col[c], er, ec);
      end
      total++;
      if (obs_pe[c] !== ep) begin
        bad++;
        $display("FAIL hold_pe_en c=%0d got=%b want=%b", c, obs_pe[c], ep);
      end
      total++;
      if (obs_done[c] !== (c == 13) || obs_busy[c] !== (c <= 13)) begin
        bad++;
        $display("FAIL hold_done_busy c=%0d got done=%b busy=%b want done=%b busy=%b",
                 c, obs_done[c], obs_busy[c], (c == 13), (c <= 13));
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (acc[i][j] !== EXP_X[i][j]) begin
          bad++;
          $display("FAIL hold_array pe(%0d,%0d) got=%0d want=%0d", i, j, acc[i][j], EXP_X[i][j]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [23:0] er;
    mat_x = X_TEST;
    mat_y = Y_ID;
    record(15, 0, 0, (32'd1 << 5) | (32'd1 << 7) | (32'd1 << 10), 4, {9{8'h55}});
    for (int c = 1; c <= 15; c++) begin
      er = (c >= 2 && c <= 9) ? EXP_ROW[c-2] : 24'd0;
      total++;
      if (obs_row[c] !== er) begin
        bad++;
        $display("FAIL ignore_row c=%0d got=%h want=%h", c, obs_row[c], er);
      end
      total++;
      if (obs_done[c] !== (c == 10) || obs_busy[c] !== (c <= 10) || obs_clr[c] !== (c == 1)) begin
        bad++;
        $display("FAIL ignore_ctrl c=%0d got done=%b busy=%b clr=%b want done=%b busy=%b clr=%b",
                 c, obs_done[c], obs_busy[c], obs_clr[c], (c == 10), (c <= 10), (c == 1));
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (acc[i][j] !== EXP_X[i][j]) begin
          bad++;
          $display("FAIL ignore_array pe(%0d,%0d) got=%0d want=%0d", i, j, acc[i][j], EXP_X[i][j]);
        end
      end
    end
    mat_x = X_TEST;
  endtask

  task automatic test_abort();
    mat_x = X_TEST;
    mat_y = Y_ID;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (out_row !== 24'h000608 || pe_en !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_t3 got row=%h pe=%b want row=000608 pe=1", out_row, pe_en);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_row, out_col, pe_en, acc_clr, busy, done} !== 52'd0) begin
      bad++;
      $display("FAIL abort_async got row=%h col=%h pe=%b clr=%b busy=%b done=%b want all 0",
               out_row, out_col, pe_en, acc_clr, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_done c=%0d got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    test_skew();
  endtask

  task automatic test_signed();
    mat_x = {9{8'h80}};
    mat_y = {9{8'h7F}};
    record(12, 0, 0, 32'd0, 0, 72'd0);
    total++;
    if (obs_row[2] !== 24'h800000 || obs_col[2] !== 24'h7F0000) begin
      bad++;
      $display("FAIL signed_t0 got row=%h col=%h want row=800000 col=7f0000", obs_row[2], obs_col[2]);
    end
    total++;
    if (obs_row[4] !== 24'h808080 || obs_col[4] !== 24'h7F7F7F) begin
      bad++;
      $display("FAIL signed_t2 got row=%h col=%h want row=808080 col=7f7f7f", obs_row[4], obs_col[4]);
    end
    total++;
    if (obs_done[10] !== 1'b1) begin
      bad++;
      $display("FAIL signed_done got=%b want=1", obs_done[10]);
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (acc[i][j] !== -48768) begin
          bad++;
          $display("FAIL signed_array pe(%0d,%0d) got=%0d want=-48768", i, j, acc[i][j]);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    mat_x = '0;
    mat_y = '0;
    test_reset();
    test_skew();
    test_hold();
    test_start_ignored();
    test_abort();
    test_signed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
